// File: rtl/in_service_register_pkg.sv
// Shared constants for the in-service register slice: INTA phase codes,
// FSM state encoding and level-index width.
package in_service_register_pkg;

  localparam int N_IRQ = 8;
  localparam int LVL_W = 3;

  // INTA phase as reported by the control block
  localparam logic [1:0] INTA_IDLE   = 2'd0;
  localparam logic [1:0] INTA_FIRST  = 2'd1;
  localparam logic [1:0] INTA_SECOND = 2'd2;

  // Acknowledge-sequence FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_ACK2 = 2'd2;

endpackage

// File: rtl/in_service_register_if.sv
// Control/status bundle between the 8259A control logic and the in-service
// register. master = control side, slave = the ISR block.
interface in_service_register_if
  import in_service_register_pkg::*;
  ();

  logic [1:0]       inta_count;
  logic [N_IRQ-1:0] serviced_interrupt;
  logic             eoi;
  logic             eoi_specific;
  logic [LVL_W-1:0] eoi_level;
  logic             aeoi_mode;
  logic             rotate;
  logic [LVL_W-1:0] lowest_priority;
  logic [4:0]       icw2_base;

  logic [N_IRQ-1:0] isr;
  logic [N_IRQ-1:0] irr_clear;
  logic [7:0]       vector_out;
  logic             vector_valid;
  logic             spurious;
  logic             eoi_ignored;
  logic             rot_update;
  logic [LVL_W-1:0] rot_level;

  modport master (
    output inta_count, serviced_interrupt, eoi, eoi_specific, eoi_level,
           aeoi_mode, rotate, lowest_priority, icw2_base,
    input  isr, irr_clear, vector_out, vector_valid, spurious,
           eoi_ignored, rot_update, rot_level
  );

  modport slave (
    input  inta_count, serviced_interrupt, eoi, eoi_specific, eoi_level,
           aeoi_mode, rotate, lowest_priority, icw2_base,
    output isr, irr_clear, vector_out, vector_valid, spurious,
           eoi_ignored, rot_update, rot_level
  );

endinterface

// File: rtl/in_service_register_priority_finder.sv
// Combinational rotating find-first. With rot=0 the search starts at bit 0;
// with rot=1 it starts at 'base' and wraps, so the first set bit met in
// that order is reported.
module isr_priority_finder
  import in_service_register_pkg::*;
(
  input  logic [N_IRQ-1:0] vec,
  input  logic [LVL_W-1:0] base,
  input  logic             rot,
  output logic             found,
  output logic [LVL_W-1:0] level
);

  logic [LVL_W-1:0] start;
  logic [LVL_W-1:0] idx;

  // Scan from the farthest offset back to the start so the nearest hit wins
  always_comb begin
    found = 1'b0;
    level = '0;
    idx   = '0;
    start = rot ? base : '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = start + LVL_W'(i);
      if (vec[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/in_service_register.sv
// In-service register of the 8259A: latches the resolver winner on the first
// INTA, emits the vector on the second, and retires levels on EOI/AEOI.
module in_service_register
  import in_service_register_pkg::*;
(
  input  logic                  internal_clk,
  input  logic                  reset,
  in_service_register_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       inta_q, inta_d;
  logic             armed_q, armed_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             spur_q, spur_d;
  logic [N_IRQ-1:0] irr_clear_q, irr_clear_d;
  logic [7:0]       vector_out_q, vector_out_d;
  logic             vector_valid_q, vector_valid_d;
  logic             spurious_q, spurious_d;
  logic             eoi_ignored_q, eoi_ignored_d;
  logic             rot_update_q, rot_update_d;
  logic [LVL_W-1:0] rot_level_q, rot_level_d;

  logic             entry_first, entry_second;
  logic             pick_found, ns_found;
  logic [LVL_W-1:0] pick_lvl, ns_lvl, ns_base;
  logic [N_IRQ-1:0] set_mask, clr_mask;
  logic             eoi_rot, aeoi_rot;

  // armed_q is low only on the first clock after reset, so a phase already
  // pending at release just reloads inta_q instead of counting as an entry.
  assign entry_first  = armed_q && (bus.inta_count == INTA_FIRST)  && (inta_q != INTA_FIRST);
  assign entry_second = armed_q && (bus.inta_count == INTA_SECOND) && (inta_q != INTA_SECOND);

  assign ns_base = bus.lowest_priority + LVL_W'(1);

  isr_priority_finder u_pick (
    .vec   (bus.serviced_interrupt),
    .base  ('0),
    .rot   (1'b0),
    .found (pick_found),
    .level (pick_lvl)
  );

  isr_priority_finder u_eoi_find (
    .vec   (isr_q),
    .base  (ns_base),
    .rot   (bus.rotate),
    .found (ns_found),
    .level (ns_lvl)
  );

  // Acknowledge-sequence state tracking
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (entry_first) state_d = ST_ACK1;
      ST_ACK1: begin
        if (entry_second)                        state_d = ST_ACK2;
        else if (bus.inta_count == INTA_IDLE)    state_d = ST_IDLE;
      end
      ST_ACK2: if (bus.inta_count == INTA_IDLE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch, vector, AEOI and EOI handling; clears act on pre-edge isr, set wins
  always_comb begin
    inta_d         = bus.inta_count;
    armed_d        = 1'b1;
    lvl_d          = lvl_q;
    spur_d         = spur_q;
    irr_clear_d    = '0;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    spurious_d     = 1'b0;
    eoi_ignored_d  = 1'b0;
    rot_level_d    = rot_level_q;
    set_mask       = '0;
    clr_mask       = '0;
    eoi_rot        = 1'b0;
    aeoi_rot       = 1'b0;

    if (entry_first) begin
      if (pick_found) begin
        set_mask    = N_IRQ'(1) << pick_lvl;
        irr_clear_d = N_IRQ'(1) << pick_lvl;
        lvl_d       = pick_lvl;
        spur_d      = 1'b0;
      end else begin
        spurious_d  = 1'b1;
        lvl_d       = LVL_W'(N_IRQ - 1);
        spur_d      = 1'b1;
      end
    end

    if (entry_second) begin
      vector_out_d   = {bus.icw2_base, lvl_q};
      vector_valid_d = 1'b1;
      if (bus.aeoi_mode && !spur_q) begin
        clr_mask = clr_mask | (N_IRQ'(1) << lvl_q);
        aeoi_rot = bus.rotate;
      end
    end

    if (bus.eoi) begin
      if (bus.eoi_specific) begin
        if (isr_q[bus.eoi_level]) begin
          clr_mask = clr_mask | (N_IRQ'(1) << bus.eoi_level);
          eoi_rot  = bus.rotate;
        end else begin
          eoi_ignored_d = 1'b1;
        end
      end else begin
        if (ns_found) begin
          clr_mask = clr_mask | (N_IRQ'(1) << ns_lvl);
          eoi_rot  = bus.rotate;
        end else begin
          eoi_ignored_d = 1'b1;
        end
      end
    end

    if (eoi_rot)       rot_level_d = bus.eoi_specific ? bus.eoi_level : ns_lvl;
    else if (aeoi_rot) rot_level_d = lvl_q;

    rot_update_d = eoi_rot | aeoi_rot;
    isr_d        = (isr_q & ~clr_mask) | set_mask;
  end

  // State and registered outputs
  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      inta_q         <= INTA_IDLE;
      armed_q        <= 1'b0;
      isr_q          <= '0;
      lvl_q          <= '0;
      spur_q         <= 1'b0;
      irr_clear_q    <= '0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
      spurious_q     <= 1'b0;
      eoi_ignored_q  <= 1'b0;
      rot_update_q   <= 1'b0;
      rot_level_q    <= '0;
    end else begin
      state_q        <= state_d;
      inta_q         <= inta_d;
      armed_q        <= armed_d;
      isr_q          <= isr_d;
      lvl_q          <= lvl_d;
      spur_q         <= spur_d;
      irr_clear_q    <= irr_clear_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      spurious_q     <= spurious_d;
      eoi_ignored_q  <= eoi_ignored_d;
      rot_update_q   <= rot_update_d;
      rot_level_q    <= rot_level_d;
    end
  end

  assign bus.isr          = isr_q;
  assign bus.irr_clear    = irr_clear_q;
  assign bus.vector_out   = vector_out_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.spurious     = spurious_q;
  assign bus.eoi_ignored  = eoi_ignored_q;
  assign bus.rot_update   = rot_update_q;
  assign bus.rot_level    = rot_level_q;

endmodule

// File: tb/tb_in_service_register.sv
// Bench for in_service_register: directed scenarios plus randomized INTA/EOI
// traffic, checked by a queue-based scoreboard against a behavioural model.
module tb_in_service_register;

  typedef struct packed {
    logic [7:0] isr;
    logic [7:0] irr;
    logic [7:0] vec;
    logic       vv;
    logic       spur;
    logic       ign;
    logic       rotu;
    logic [2:0] rotl;
  } exp_t;

  logic internal_clk = 1'b0;
  logic reset        = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // behavioural model state
  bit [7:0] m_isr;
  bit [7:0] m_vec;
  int       m_rotl, m_lvl, m_prev;
  bit       m_spur, m_first;

  in_service_register_if bus();

  in_service_register u_dut (
    .internal_clk (internal_clk),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 internal_clk = ~internal_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Apply current inputs for one clock: predict outputs, queue them, advance.
  task automatic step();
    exp_t e;
    bit [7:0] clr, set;
    int inta, found;
    bit entry1, entry2;
    e = '0;
    clr = '0;
    set = '0;
    if (reset) begin
      m_isr = '0; m_vec = '0; m_rotl = 0; m_lvl = 0; m_prev = 0;
      m_spur = 1'b0; m_first = 1'b1;
    end else begin
      inta   = int'(bus.inta_count);
      entry1 = !m_first && inta == 1 && m_prev != 1;
      entry2 = !m_first && inta == 2 && m_prev != 2;
      if (entry2) begin
        m_vec = {bus.icw2_base, 3'(m_lvl)};
        e.vv  = 1'b1;
        if (bus.aeoi_mode && !m_spur) begin
          clr[m_lvl] = 1'b1;
          if (bus.rotate) begin
            e.rotu = 1'b1;
            m_rotl = m_lvl;
          end
        end
      end
      if (entry1) begin
        found = -1;
        for (int i = 0; i < 8; i++)
          if (bus.serviced_interrupt[i] && found < 0) found = i;
        if (found >= 0) begin
          set[found]   = 1'b1;
          e.irr[found] = 1'b1;
          m_lvl  = found;
          m_spur = 1'b0;
        end else begin
          e.spur = 1'b1;
          m_lvl  = 7;
          m_spur = 1'b1;
        end
      end
      if (bus.eoi) begin
        if (bus.eoi_specific) begin
          if (!m_isr[bus.eoi_level]) e.ign = 1'b1;
          else begin
            clr[bus.eoi_level] = 1'b1;
            if (bus.rotate) begin
              e.rotu = 1'b1;
              m_rotl = int'(bus.eoi_level);
            end
          end
        end else if (m_isr == 0) begin
          e.ign = 1'b1;
        end else begin
          found = -1;
          for (int k = 1; k <= 8; k++) begin
            int j;
            j = bus.rotate ? (int'(bus.lowest_priority) + k) % 8 : k - 1;
            if (m_isr[j] && found < 0) found = j;
          end
          clr[found] = 1'b1;
          if (bus.rotate) begin
            e.rotu = 1'b1;
            m_rotl = found;
          end
        end
      end
      m_isr   = (m_isr & ~clr) | set;
      m_prev  = inta;
      m_first = 1'b0;
      e.isr   = m_isr;
      e.vec   = m_vec;
      e.rotl  = 3'(m_rotl);
    end
    sb_q.push_back(e);
    @(negedge internal_clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic ack(input logic [7:0] si);
    bus.serviced_interrupt = si;
    bus.inta_count = 2'd1; step();
    bus.inta_count = 2'd2; step();
    bus.inta_count = 2'd0; step();
  endtask

  task automatic pulse_eoi(input logic spec, input logic [2:0] lvl);
    bus.eoi = 1'b1; bus.eoi_specific = spec; bus.eoi_level = lvl;
    step();
    bus.eoi = 1'b0;
  endtask

  // Scoreboard monitor: one prediction per clock, compared after the edge
  initial begin
    exp_t e, a;
    forever begin
      @(posedge internal_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {bus.isr, bus.irr_clear, bus.vector_out, bus.vector_valid,
             bus.spurious, bus.eoi_ignored, bus.rot_update, bus.rot_level};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t: actual isr=%h irr=%h vec=%h vv=%b sp=%b ign=%b ru=%b rl=%0d required isr=%h irr=%h vec=%h vv=%b sp=%b ign=%b ru=%b rl=%0d",
                   $time, a.isr, a.irr, a.vec, a.vv, a.spur, a.ign, a.rotu, a.rotl,
                   e.isr, e.irr, e.vec, e.vv, e.spur, e.ign, e.rotu, e.rotl);
        end
      end
    end
  end

  initial begin
    bus.inta_count = 2'd0; bus.serviced_interrupt = 8'h00; bus.eoi = 1'b0;
    bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0; bus.aeoi_mode = 1'b0;
    bus.rotate = 1'b0; bus.lowest_priority = 3'd7; bus.icw2_base = 5'h11;
    reset = 1'b1;
    step(); step();
    chk("reset_isr", bus.isr, 8'h00);
    chk("reset_vector", bus.vector_out, 8'h00);
    reset = 1'b0;
    step();

    // 1: latch level 3 and deliver vector 0x8B
    bus.serviced_interrupt = 8'h08;
    bus.inta_count = 2'd1; step();
    chk("t1_isr", bus.isr, 8'h08);
    chk("t1_irr_clear", bus.irr_clear, 8'h08);
    bus.inta_count = 2'd2; step();
    chk("t1_vector", bus.vector_out, 8'h8B);
    chk("t1_vector_valid", {7'd0, bus.vector_valid}, 8'h01);
    chk("t1_irr_pulse_ends", bus.irr_clear, 8'h00);
    bus.inta_count = 2'd0; step();

    // 2: fixed-priority non-specific EOIs
    ack(8'h02);
    chk("t2_isr_setup", bus.isr, 8'h0A);
    pulse_eoi(1'b0, 3'd0);
    chk("t2_eoi1", bus.isr, 8'h08);
    pulse_eoi(1'b0, 3'd0);
    chk("t2_eoi2", bus.isr, 8'h00);
    pulse_eoi(1'b0, 3'd0);
    chk("t2_ignored", {7'd0, bus.eoi_ignored}, 8'h01);

    // 3: rotating non-specific EOI starts after lowest_priority
    ack(8'h80);
    ack(8'h02);
    bus.rotate = 1'b1; bus.lowest_priority = 3'd2;
    pulse_eoi(1'b0, 3'd0);
    chk("t3_isr", bus.isr, 8'h02);
    chk("t3_rot_update", {7'd0, bus.rot_update}, 8'h01);
    chk("t3_rot_level", {5'd0, bus.rot_level}, 8'h07);
    pulse_eoi(1'b0, 3'd0);
    bus.rotate = 1'b0; bus.lowest_priority = 3'd7;

    // 4: automatic EOI
    bus.aeoi_mode = 1'b1;
    bus.serviced_interrupt = 8'h01;
    bus.inta_count = 2'd1; step();
    bus.inta_count = 2'd2; step();
    chk("t4_isr_after_aeoi", bus.isr, 8'h00);
    chk("t4_vector", bus.vector_out, 8'h88);
    bus.inta_count = 2'd0; step();
    bus.aeoi_mode = 1'b0;

    // 5: spurious first INTA
    bus.serviced_interrupt = 8'h00;
    bus.inta_count = 2'd1; step();
    chk("t5_spurious", {7'd0, bus.spurious}, 8'h01);
    chk("t5_isr", bus.isr, 8'h00);
    bus.inta_count = 2'd2; step();
    chk("t5_vector_lvl", {5'd0, bus.vector_out[2:0]}, 8'h07);
    bus.inta_count = 2'd0; step();

    // 6: set wins over same-cycle specific EOI, then reset in ACK1
    ack(8'h08);
    bus.serviced_interrupt = 8'h08;
    bus.eoi = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd3;
    bus.inta_count = 2'd1; step();
    bus.eoi = 1'b0;
    chk("t6_set_wins", bus.isr, 8'h08);
    reset = 1'b1; step();
    chk("t6_reset_isr", bus.isr, 8'h00);
    chk("t6_reset_state", {6'd0, u_dut.state_q}, 8'h00);
    reset = 1'b0; step();
    chk("t6_no_reentry_irr", bus.irr_clear, 8'h00);
    chk("t6_no_reentry_isr", bus.isr, 8'h00);
    bus.inta_count = 2'd0; step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r == 0);
      case (bus.inta_count)
        2'd0: if ($urandom_range(0, 9) < 3) bus.inta_count = 2'd1;
        2'd1: begin
          r = int'($urandom_range(0, 9));
          if (r < 5) bus.inta_count = 2'd2;
          else if (r == 5) bus.inta_count = 2'd0;
        end
        default: if ($urandom_range(0, 1) == 1) bus.inta_count = 2'd0;
      endcase
      r = int'($urandom_range(0, 9));
      if (r < 2)      bus.serviced_interrupt = 8'h00;
      else if (r < 6) bus.serviced_interrupt = 8'h01 << $urandom_range(0, 7);
      else            bus.serviced_interrupt = 8'($urandom);
      bus.eoi             = ($urandom_range(0, 4) == 0);
      bus.eoi_specific    = 1'($urandom);
      bus.eoi_level       = 3'($urandom);
      bus.aeoi_mode       = ($urandom_range(0, 3) == 0);
      bus.rotate          = 1'($urandom);
      bus.lowest_priority = 3'($urandom);
      bus.icw2_base       = 5'($urandom);
      step();
    end
    reset = 1'b0;
    bus.eoi = 1'b0;
    bus.inta_count = 2'd0;
    step();
    @(negedge internal_clk);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 pending", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
